// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges ALU and LSU register-file writes onto one write port.
// LSU has priority, and a saturating starvation counter guarantees the ALU a turn.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef GP_REG_COUNT
`define GP_REG_COUNT 32
`endif

module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid_i,
    input  logic [$clog2(`GP_REG_COUNT)-1:0]  alu_addr_i,
    input  logic [`RISCV_WORD_WIDTH-1:0]      alu_data_i,
    output logic                              alu_ready_o,
    input  logic                              lsu_valid_i,
    input  logic [$clog2(`GP_REG_COUNT)-1:0]  lsu_addr_i,
    input  logic [`RISCV_WORD_WIDTH-1:0]      lsu_data_i,
    output logic                              lsu_ready_o,
    output logic                              rf_write_en_o,
    output logic [$clog2(`GP_REG_COUNT)-1:0]  rf_write_addr_o,
    output logic [`RISCV_WORD_WIDTH-1:0]      rf_write_data_o,
    output logic [2:0]                        starve_cnt_o
);

    localparam int unsigned AddrWidth = $clog2(`GP_REG_COUNT);
    localparam int unsigned DataWidth = `RISCV_WORD_WIDTH;
    localparam logic [2:0]  StarveMax = 3'(STARVE_LIMIT);

    logic                 r_wen;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_data;
    logic [2:0]           r_starve;

    logic                 w_force_alu;
    logic                 w_alu_grant;
    logic                 w_lsu_grant;
    logic                 w_xfer;
    logic                 w_write;
    logic [AddrWidth-1:0] w_sel_addr;
    logic [DataWidth-1:0] w_sel_data;
    logic [2:0]           w_starve_d;

    always_comb begin
        w_force_alu = alu_valid_i && (r_starve == StarveMax);
        w_lsu_grant = !rst && lsu_valid_i && !w_force_alu;
        w_alu_grant = !rst && alu_valid_i && (w_force_alu || !lsu_valid_i);
        w_xfer      = w_alu_grant || w_lsu_grant;
        w_sel_addr  = w_alu_grant ? alu_addr_i : lsu_addr_i;
        w_sel_data  = w_alu_grant ? alu_data_i : lsu_data_i;
        // x0 is hardwired zero: the handshake completes but nothing is written.
        w_write     = w_xfer && (w_sel_addr != '0);

        w_starve_d = '0;
        if (alu_valid_i && !w_alu_grant) begin
            w_starve_d = (r_starve == StarveMax) ? r_starve : r_starve + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_starve <= '0;
        end else begin
            r_wen    <= w_write;
            r_starve <= w_starve_d;
            if (w_write) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    // Gating with rst drops a write captured just before reset asserted.
    assign rf_write_en_o   = r_wen && !rst;
    assign rf_write_addr_o = rst ? '0 : r_addr;
    assign rf_write_data_o = rst ? '0 : r_data;
    assign alu_ready_o     = w_alu_grant;
    assign lsu_ready_o     = w_lsu_grant;
    assign starve_cnt_o    = r_starve;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal expectations,
// plus a cycle-by-cycle comparison against a rule-level model of the arbiter.
module tb_wb_port_arbiter;

    localparam int unsigned Limit = 2;

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;
    logic        rf_write_en_o;
    logic [4:0]  rf_write_addr_o;
    logic [31:0] rf_write_data_o;
    logic [2:0]  starve_cnt_o;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid_i     (alu_valid_i),
        .alu_addr_i      (alu_addr_i),
        .alu_data_i      (alu_data_i),
        .alu_ready_o     (alu_ready_o),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_ready_o     (lsu_ready_o),
        .rf_write_en_o   (rf_write_en_o),
        .rf_write_addr_o (rf_write_addr_o),
        .rf_write_data_o (rf_write_data_o),
        .starve_cnt_o    (starve_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the edge, return at the mid-cycle negedge.
    task automatic cyc(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        rst = r; alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
        lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Model state: expected registered write, held output values, ALU denial streak.
    logic        m_wen = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_known = 1'b1;
    int          m_streak = 0;
    logic        ea, el;
    logic [4:0]  t_addr;
    logic [31:0] t_data;
    logic [31:0] d_rf [32];

    initial begin
        for (int i = 0; i < 32; i++) d_rf[i] = '0;
        forever begin
            @(negedge clk);
            ea = 1'b0;
            el = 1'b0;
            if (!rst) begin
                if (alu_valid_i && m_streak >= Limit) ea = 1'b1;
                else if (lsu_valid_i)                 el = 1'b1;
                else                                  ea = alu_valid_i;
            end
            chk("model alu_ready", 32'(alu_ready_o), 32'(ea));
            chk("model lsu_ready", 32'(lsu_ready_o), 32'(el));
            if (rst) begin
                chk("model rst en", 32'(rf_write_en_o), 32'h0);
                chk("model rst addr", 32'(rf_write_addr_o), 32'h0);
                chk("model rst data", rf_write_data_o, 32'h0);
            end else begin
                chk("model en", 32'(rf_write_en_o), 32'(m_wen));
                chk("model starve", 32'(starve_cnt_o), 32'(m_streak));
                if (m_wen || m_known) begin
                    chk("model addr", 32'(rf_write_addr_o), 32'(m_addr));
                    chk("model data", rf_write_data_o, m_data);
                end
                if (rf_write_en_o) d_rf[rf_write_addr_o] = rf_write_data_o;
            end
            if (rst) begin
                m_wen = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1; m_streak = 0;
            end else begin
                t_addr = ea ? alu_addr_i : lsu_addr_i;
                t_data = ea ? alu_data_i : lsu_data_i;
                m_wen = 1'b0;
                if (ea || el) begin
                    if (t_addr != 0) begin
                        m_wen = 1'b1; m_addr = t_addr; m_data = t_data; m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                end
                if (alu_valid_i && !ea) m_streak = (m_streak < Limit) ? m_streak + 1 : Limit;
                else                    m_streak = 0;
            end
        end
    end

    logic [5:0] alu_order;
    int         starve_seq [6];

    initial begin
        rst = 1'b1;
        alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;

        // Reset: valids high, nothing granted, outputs zero.
        cyc(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("rst alu_ready", 32'(alu_ready_o), 32'h0);
        chk("rst lsu_ready", 32'(lsu_ready_o), 32'h0);
        cyc(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("rst en", 32'(rf_write_en_o), 32'h0);
        chk("rst starve", 32'(starve_cnt_o), 32'h0);

        // LSU only.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("lsu only ready", 32'(lsu_ready_o), 32'h1);
        chk("lsu only alu_ready", 32'(alu_ready_o), 32'h0);
        idle();
        chk("lsu only en", 32'(rf_write_en_o), 32'h1);
        chk("lsu only addr", 32'(rf_write_addr_o), 32'h5);
        chk("lsu only data", rf_write_data_o, 32'hDEADBEEF);
        idle();
        chk("single pulse en", 32'(rf_write_en_o), 32'h0);
        chk("hold addr", 32'(rf_write_addr_o), 32'h5);

        // Both valid continuously: LSU, LSU, ALU, LSU, LSU, ALU.
        alu_order  = 6'b100100;
        starve_seq = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 5'd10, 32'hA0 + 32'(i), 1'b1, 5'd11, 32'hB0 + 32'(i));
            chk("starve alu_ready", 32'(alu_ready_o), 32'(alu_order[i]));
            chk("starve lsu_ready", 32'(lsu_ready_o), 32'(!alu_order[i]));
            chk("starve count", 32'(starve_cnt_o), 32'(starve_seq[i]));
        end
        idle();

        // ALU write to x0.
        cyc(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        chk("x0 alu_ready", 32'(alu_ready_o), 32'h1);
        idle();
        chk("x0 no write", 32'(rf_write_en_o), 32'h0);

        // Same destination on both ports: LSU first, ALU overwrites.
        cyc(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        chk("x7 lsu first", 32'(lsu_ready_o), 32'h1);
        cyc(1'b0, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0);
        chk("x7 alu second", 32'(alu_ready_o), 32'h1);
        chk("x7 lsu data", rf_write_data_o, 32'h2);
        idle();
        chk("x7 alu en", 32'(rf_write_en_o), 32'h1);
        chk("x7 alu data", rf_write_data_o, 32'h1);
        idle();
        chk("x7 final", d_rf[7], 32'h1);

        // Reset right after an LSU transfer discards the write.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
        chk("pre-rst lsu_ready", 32'(lsu_ready_o), 32'h1);
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("rst discard en", 32'(rf_write_en_o), 32'h0);
        chk("rst discard data", rf_write_data_o, 32'h0);
        idle();
        chk("post-rst en", 32'(rf_write_en_o), 32'h0);
        chk("post-rst addr", 32'(rf_write_addr_o), 32'h0);
        chk("post-rst starve", 32'(starve_cnt_o), 32'h0);

        // ALU drops for one cycle at count 1: counter clears, LSU keeps winning.
        cyc(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
        cyc(1'b0, 1'b0, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hD1);
        chk("drop count1", 32'(starve_cnt_o), 32'h1);
        cyc(1'b0, 1'b1, 5'd12, 32'hC2, 1'b1, 5'd13, 32'hD2);
        chk("drop cleared", 32'(starve_cnt_o), 32'h0);
        chk("drop lsu wins", 32'(lsu_ready_o), 32'h1);
        idle();

        // Mixed traffic, small address range to hit x0 and collisions, occasional reset.
        for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end
        idle();
        idle();

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
